led_pwm_driver: RTL and testbench

Downstream consumer of the register block and LED mux in the register-test design. It converts per-channel duty values, held in registers written over the UART command parser, into PWM waveforms on the board LEDs. The LED mux output acts as a per-channel on/off mask. The block makes LED brightness register-controllable without changing the LED mux path.

---
 rtl/led_pwm_driver.sv | 108 ++++++++++
 tb/tb_led_pwm_driver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_driver.sv
// ---------------------------------------------------------------------------
// led_pwm_driver
//
// Turns per-channel duty registers into PWM waveforms on the board LEDs.
// A prescaler divides clk into phase steps. A phase counter sweeps
// 0 .. 2^DUTY_WIDTH-2, so one PWM period is PRESCALE*(2^DUTY_WIDTH-1) cycles.
// Duties are captured into shadow registers at each period start, so a
// brightness change never lands part-way through a period. The LED mux output
// (i_mask) is applied unshadowed, so it gates the channel immediately.
//
// Ports:
//   clk            system clock
//   i_reset        asynchronous, active-high reset
//   i_enable       global PWM enable (level)
//   i_duty         packed duties, channel k = [k*DUTY_WIDTH +: DUTY_WIDTH]
//   i_mask         per-channel gate, 1 = channel may light
//   o_led          registered PWM outputs, polarity set by ACTIVE_LOW
//   o_period_start registered one-cycle pulse at the start of each period
// ---------------------------------------------------------------------------
module led_pwm_driver #(
    parameter int N_CHANNELS = 8,
    parameter int DUTY_WIDTH = 8,
    parameter int PRESCALE   = 196,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                             clk,
    input  logic                             i_reset,
    input  logic                             i_enable,
    input  logic [N_CHANNELS*DUTY_WIDTH-1:0] i_duty,
    input  logic [N_CHANNELS-1:0]            i_mask,
    output logic [N_CHANNELS-1:0]            o_led,
    output logic                             o_period_start
);

    // A 1-bit prescaler when PRESCALE==1 keeps the declarations legal; it
    // then simply stays at 0 because every cycle is the last step cycle.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [DUTY_WIDTH-1:0] PHASE_LAST = DUTY_WIDTH'((2 ** DUTY_WIDTH) - 2);
    localparam logic [N_CHANNELS-1:0] LED_OFF    = {N_CHANNELS{ACTIVE_LOW}};

    logic [PW-1:0]                           presc_q, presc_d;
    logic [DUTY_WIDTH-1:0]                   phase_q, phase_d;
    logic [N_CHANNELS-1:0][DUTY_WIDTH-1:0]   shadow_q, shadow_d;
    logic [N_CHANNELS-1:0]                   led_q, led_d;
    logic                                    period_start_q, period_start_d;

    logic                                    period_start;
    logic                                    step_last;
    logic [N_CHANNELS-1:0][DUTY_WIDTH-1:0]   cmp_val;
    logic [N_CHANNELS-1:0]                   chan_on;

    always_comb begin
        presc_d        = presc_q;
        phase_d        = phase_q;
        shadow_d       = shadow_q;
        cmp_val        = shadow_q;
        chan_on        = '0;
        period_start   = i_enable && (presc_q == '0) && (phase_q == '0);
        step_last      = (presc_q == PRESC_LAST);

        // Counters only run while enabled; disabling parks them at the
        // period origin so the next enabled cycle is a period start.
        if (!i_enable) begin
            presc_d = '0;
            phase_d = '0;
        end else if (step_last) begin
            presc_d = '0;
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + DUTY_WIDTH'(1);
        end else begin
            presc_d = presc_q + PW'(1);
        end

        for (int k = 0; k < N_CHANNELS; k++) begin
            // In the period-start cycle the shadow is still the old value,
            // so compare against the incoming duty directly; this lets the
            // new duty govern the very first step of the period.
            if (period_start) begin
                shadow_d[k] = i_duty[k*DUTY_WIDTH +: DUTY_WIDTH];
                cmp_val[k]  = i_duty[k*DUTY_WIDTH +: DUTY_WIDTH];
            end
            chan_on[k] = i_enable && i_mask[k] && (phase_q < cmp_val[k]);
        end

        led_d          = chan_on ^ LED_OFF;
        period_start_d = period_start;
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            presc_q        <= '0;
            phase_q        <= '0;
            shadow_q       <= '0;
            led_q          <= LED_OFF;
            period_start_q <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            phase_q        <= phase_d;
            shadow_q       <= shadow_d;
            led_q          <= led_d;
            period_start_q <= period_start_d;
        end
    end

    assign o_led          = led_q;
    assign o_period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_led_pwm_driver
//
// Bench for led_pwm_driver. A small instance (DUTY_WIDTH=4, PRESCALE=2,
// active-low, 30-cycle period) is checked cycle by cycle against a reference
// model that works from "enabled cycle count since the period origin":
// position = count mod period, phase = position / PRESCALE, and a channel is
// lit when its duty latched at position 0 exceeds the phase. A second,
// full-size active-high instance is measured over one whole period.
// ---------------------------------------------------------------------------
module tb_led_pwm_driver;

    localparam int NCH    = 8;
    localparam int DW     = 4;
    localparam int PS     = 2;
    localparam int PERIOD = PS * ((1 << DW) - 1);

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst;

    // Small instance
    logic              en;
    logic [DW-1:0]     duty [NCH];
    logic [NCH*DW-1:0] duty_bus;
    logic [NCH-1:0]    mask;
    logic [NCH-1:0]    led;
    logic              ps;

    // Full-size instance
    logic              en6;
    logic [NCH*8-1:0]  duty6_bus;
    logic [NCH-1:0]    mask6;
    logic [NCH-1:0]    led6;
    logic              ps6;

    // Reference model state
    int                en_cnt;
    int                latch [NCH];
    logic [NCH-1:0]    exp_led;
    logic              exp_ps;

    int n_tests = 0;
    int n_fail  = 0;

    always_comb begin
        for (int k = 0; k < NCH; k++) duty_bus[k*DW +: DW] = duty[k];
    end

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    led_pwm_driver #(.N_CHANNELS(NCH), .DUTY_WIDTH(DW), .PRESCALE(PS), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .i_reset(rst), .i_enable(en), .i_duty(duty_bus),
        .i_mask(mask), .o_led(led), .o_period_start(ps)
    );

    led_pwm_driver #(.N_CHANNELS(NCH), .DUTY_WIDTH(8), .PRESCALE(196), .ACTIVE_LOW(1'b0)) dut6 (
        .clk(clk), .i_reset(rst), .i_enable(en6), .i_duty(duty6_bus),
        .i_mask(mask6), .o_led(led6), .o_period_start(ps6)
    );

    // Advance the reference model by the cycle about to be clocked, using
    // the inputs as they stand, then move past the edge.
    task automatic tick();
        logic [NCH-1:0] on;
        int pos;
        int phase;
        on = '0;
        if (rst) begin
            en_cnt = 0;
            for (int k = 0; k < NCH; k++) latch[k] = 0;
            exp_ps = 1'b0;
        end else if (en) begin
            pos = en_cnt % PERIOD;
            if (pos == 0) for (int k = 0; k < NCH; k++) latch[k] = int'(duty[k]);
            phase = pos / PS;
            for (int k = 0; k < NCH; k++) on[k] = mask[k] && (latch[k] > phase);
            exp_ps = (pos == 0);
            en_cnt++;
        end else begin
            en_cnt = 0;
            exp_ps = 1'b0;
        end
        exp_led = ~on;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; en6 = 1'b0; mask = '1; mask6 = '0; duty6_bus = '0;
        for (int k = 0; k < NCH; k++) duty[k] = '0;
        #3;
        n_tests++;
        if (led !== 8'hFF) begin n_fail++; $display("FAIL reset_led_noclk: got %h want ff", led); end
        n_tests++;
        if (ps !== 1'b0) begin n_fail++; $display("FAIL reset_ps_noclk: got %b want 0", ps); end
        n_tests++;
        if (led6 !== 8'h00) begin n_fail++; $display("FAIL reset_led6_noclk: got %h want 00", led6); end
        clk_run = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            n_tests++;
            if (led !== 8'hFF || ps !== 1'b0) begin
                n_fail++; $display("FAIL reset_hold cyc %0d: led=%h ps=%b want ff 0", i, led, ps);
            end
        end
    endtask

    task automatic test_static_pattern();
        int pulses;
        int low2;
        duty[0] = 4'd0; duty[1] = 4'd15; duty[2] = 4'd5;
        for (int k = 3; k < NCH; k++) duty[k] = DW'($urandom_range(0, 15));
        mask = 8'hFF;
        en = 1'b1;
        pulses = 0; low2 = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            tick();
            if (ps) pulses++;
            if (!led[2]) low2++;
            n_tests++;
            if (led !== exp_led || ps !== exp_ps) begin
                n_fail++; $display("FAIL static cyc %0d: led=%h ps=%b want %h %b", i, led, ps, exp_led, exp_ps);
            end
        end
        n_tests++;
        if (pulses != 3) begin n_fail++; $display("FAIL static_pulses: got %0d want 3", pulses); end
        n_tests++;
        if (low2 != 30) begin n_fail++; $display("FAIL static_ch2_low: got %0d want 30", low2); end
    endtask

    task automatic test_duty_change();
        int guard;
        int low2;
        guard = 0;
        while (en_cnt % PERIOD != 7 && guard < 2 * PERIOD) begin
            tick(); guard++;
        end
        duty[2] = 4'd10;
        guard = 0;
        do begin
            tick(); guard++;
            n_tests++;
            if (led !== exp_led || ps !== exp_ps) begin
                n_fail++; $display("FAIL change cyc %0d: led=%h ps=%b want %h %b", guard, led, ps, exp_led, exp_ps);
            end
        end while (!ps && guard < 2 * PERIOD);
        n_tests++;
        if (!ps) begin n_fail++; $display("FAIL change_pulse_timeout: ps=%b want 1", ps); end
        low2 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (!led[2]) low2++;
            tick();
        end
        n_tests++;
        if (low2 != 20) begin n_fail++; $display("FAIL change_ch2_low: got %0d want 20", low2); end
    endtask

    task automatic test_mask_enable();
        duty[1] = 4'd15;
        for (int i = 0; i < 11; i++) tick();
        mask[1] = 1'b0;
        tick();
        n_tests++;
        if (led[1] !== 1'b1) begin n_fail++; $display("FAIL mask_drop: led1=%b want 1", led[1]); end
        n_tests++;
        if (led !== exp_led) begin n_fail++; $display("FAIL mask_drop_model: led=%h want %h", led, exp_led); end
        mask[1] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        en = 1'b0;
        tick();
        n_tests++;
        if (led !== 8'hFF || ps !== 1'b0) begin
            n_fail++; $display("FAIL enable_drop: led=%h ps=%b want ff 0", led, ps);
        end
        for (int i = 0; i < 5; i++) tick();
        en = 1'b1;
        tick();
        n_tests++;
        if (ps !== 1'b1) begin n_fail++; $display("FAIL enable_rise_pulse: ps=%b want 1", ps); end
        tick();
        n_tests++;
        if (ps !== 1'b0) begin n_fail++; $display("FAIL enable_rise_pulse_width: ps=%b want 0", ps); end
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            n_tests++;
            if (led !== exp_led || ps !== exp_ps) begin
                n_fail++; $display("FAIL reenable cyc %0d: led=%h ps=%b want %h %b", i, led, ps, exp_led, exp_ps);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < NCH; k++) duty[k] = DW'($urandom_range(4, 15));
        mask = 8'hFF;
        for (int i = 0; i < 2 * PERIOD + 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (led !== 8'hFF || ps !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: led=%h ps=%b want ff 0", led, ps);
        end
        tick(); tick();
        for (int k = 0; k < NCH; k++) duty[k] = DW'($urandom_range(0, 15));
        rst = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            tick();
            n_tests++;
            if (led !== exp_led || ps !== exp_ps) begin
                n_fail++; $display("FAIL post_reset cyc %0d: led=%h ps=%b want %h %b", i, led, ps, exp_led, exp_ps);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) duty[$urandom_range(0, NCH-1)] = DW'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) mask[$urandom_range(0, NCH-1)] ^= 1'b1;
            if ($urandom_range(0, 79) == 0) en = ~en;
            tick();
            n_tests++;
            if (led !== exp_led || ps !== exp_ps) begin
                n_fail++; $display("FAIL random cyc %0d: led=%h ps=%b want %h %b", i, led, ps, exp_led, exp_ps);
            end
        end
    endtask

    task automatic test_full_size();
        int guard;
        int cnt;
        int high;
        en = 1'b0;
        duty6_bus = '0;
        duty6_bus[7:0] = 8'd128;
        mask6 = 8'h01;
        en6 = 1'b1;
        guard = 0;
        do begin
            @(posedge clk); #1; guard++;
        end while (!ps6 && guard < 10);
        n_tests++;
        if (!ps6) begin n_fail++; $display("FAIL full_first_pulse: ps6=%b want 1", ps6); end
        n_tests++;
        if (led6[0] !== 1'b1) begin n_fail++; $display("FAIL full_start_level: led6_0=%b want 1", led6[0]); end
        cnt = 0; high = 0;
        do begin
            if (led6[0]) high++;
            cnt++;
            @(posedge clk); #1;
        end while (!ps6 && cnt < 60000);
        n_tests++;
        if (cnt != 49980) begin n_fail++; $display("FAIL full_period: got %0d want 49980", cnt); end
        n_tests++;
        if (high != 25088) begin n_fail++; $display("FAIL full_high: got %0d want 25088", high); end
        n_tests++;
        if (led6[7:1] !== 7'd0) begin n_fail++; $display("FAIL full_other_ch: got %h want 00", led6[7:1]); end
    endtask

    initial begin
        en_cnt = 0;
        exp_led = '1;
        exp_ps = 1'b0;
        for (int k = 0; k < NCH; k++) latch[k] = 0;
        test_reset();
        test_static_pattern();
        test_duty_change();
        test_mask_enable();
        test_async_reset();
        test_random();
        test_full_size();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
